// File: rtl/hfs_pkg.sv
// Shared types for the hazard/forward scoreboard: the per-stage record and the
// saturating Tnew decrement.
package hfs_pkg;

  localparam int HFS_NUM_SRC  = 2;
  localparam int HFS_REG_AW   = 5;
  localparam int HFS_T_W      = 4;
  localparam int HFS_MULT_CYC = 5;
  localparam int HFS_DIV_CYC  = 10;

  localparam int                  FWD_NONE    = 0;
  localparam logic [HFS_T_W-1:0]  T_NEW_READY = '0;

  typedef struct packed {
    logic                                     valid;
    logic                                     wen;
    logic [HFS_REG_AW-1:0]                    waddr;
    logic [HFS_T_W-1:0]                       tnew;
    logic [HFS_NUM_SRC-1:0][HFS_REG_AW-1:0]   src;
  } hfs_rec_t;

  // Tnew counts down to "ready" and stays there; it must never wrap.
  function automatic logic [HFS_T_W-1:0] sat_dec(input logic [HFS_T_W-1:0] t);
    return (t == T_NEW_READY) ? T_NEW_READY : t - 1'b1;
  endfunction

endpackage

// File: rtl/hfs_stage_reg.sv
// One pipeline record register of the scoreboard. Async reset, bubble insert,
// optional Tnew saturating decrement on the way in.
module hfs_stage_reg
  import hfs_pkg::*;
#(
  parameter bit DEC = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     bubble,
  input  hfs_rec_t d,
  output hfs_rec_t q
);

  hfs_rec_t nxt;

  always_comb begin
    nxt = d;
    if (DEC) nxt.tnew = sat_dec(d.tnew);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (bubble) q <= '0;
    else             q <= nxt;
  end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Hazard/forward controller: shadows the in-flight instructions after D and
// derives forward selects and the D-stage stall. Optional MDU busy tracking
// is enabled with the macro HFS_MDU_BUSY_EN.
module hazard_fwd_scoreboard
  import hfs_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = HFS_NUM_SRC,
  parameter int REG_AW     = HFS_REG_AW,
  parameter int T_W        = HFS_T_W
`ifdef HFS_MDU_BUSY_EN
  ,
  parameter int MULT_CYC   = HFS_MULT_CYC,
  parameter int DIV_CYC    = HFS_DIV_CYC
`endif
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           i_D_valid,
  input  logic [NUM_SRC*REG_AW-1:0]                      i_D_Src,
  input  logic [NUM_SRC*T_W-1:0]                         i_D_Tuse,
  input  logic [REG_AW-1:0]                              i_D_WAddr,
  input  logic                                           i_D_WEn,
  input  logic [T_W-1:0]                                 i_D_Tnew,
`ifdef HFS_MDU_BUSY_EN
  input  logic                                           i_D_MduStart,
  input  logic                                           i_D_MduDiv,
  input  logic                                           i_D_MduUse,
  output logic                                           o_MduBusy,
`endif
  output logic                                           o_Stall,
  output logic [NUM_STAGES*NUM_SRC*$clog2(NUM_STAGES+1)-1:0] o_Fwd
);

  localparam int SEL_W = $clog2(NUM_STAGES+1);

  // rec[0] is the D-stage view built from the decode inputs; rec[1..] are the
  // registered records of E, M, ... W.
  hfs_rec_t d_rec;
  hfs_rec_t stg_q [1:NUM_STAGES];
  hfs_rec_t rec   [0:NUM_STAGES];

  logic                                       ins_bubble;
  logic                                       stall_hz;
  logic [NUM_SRC-1:0]                         src_hz;
  logic [NUM_STAGES-1:0][NUM_SRC-1:0][SEL_W-1:0] fwd;

  function automatic logic prod_match(input hfs_rec_t r, input logic [REG_AW-1:0] s);
    return r.valid && r.wen && (r.waddr == s) && (s != '0);
  endfunction

  always_comb begin
    d_rec       = '0;
    d_rec.valid = 1'b1;
    d_rec.wen   = i_D_WEn;
    d_rec.waddr = i_D_WAddr;
    d_rec.tnew  = i_D_Tnew;
    d_rec.src   = i_D_Src;
  end

  always_comb begin
    rec[0] = d_rec;
    for (int k = 1; k <= NUM_STAGES; k++) rec[k] = stg_q[k];
  end

  assign ins_bubble = !(i_D_valid && !o_Stall);

  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_stg
    hfs_stage_reg #(.DEC(k > 1)) u_stg (
      .clk    (clk),
      .rst    (reset),
      .bubble ((k == 1) ? ins_bubble : 1'b0),
      .d      (rec[k-1]),
      .q      (stg_q[k])
    );
  end

  // Scan far-to-near so the nearest producer overwrites any older one.
  always_comb begin
    src_hz = '0;
    for (int j = 0; j < NUM_SRC; j++)
      for (int k = NUM_STAGES - 1; k >= 1; k--)
        if (prod_match(rec[k], rec[0].src[j]))
          src_hz[j] = rec[k].tnew > i_D_Tuse[j*T_W +: T_W];
    stall_hz = i_D_valid && (|src_hz);
  end

  // D never forwards from W: the register file writes through in that case.
  always_comb begin
    fwd = '0;
    for (int c = 0; c < NUM_STAGES; c++)
      for (int j = 0; j < NUM_SRC; j++)
        for (int k = NUM_STAGES; k > c; k--)
          if (!(c == 0 && k == NUM_STAGES) && prod_match(rec[k], rec[c].src[j]))
            fwd[c][j] = (rec[k].tnew == T_NEW_READY) ? SEL_W'(k) : SEL_W'(FWD_NONE);
  end

  assign o_Fwd = fwd;

`ifdef HFS_MDU_BUSY_EN
  localparam int MDU_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int MDU_CW  = $clog2(MDU_MAX + 1);

  logic [MDU_CW-1:0] mdu_cnt;
  logic              s1_start;
  logic              s1_div;
  logic              stall_mdu;

  // The counter starts as the start instruction leaves E, so a consumer right
  // behind it is covered by the s1_start term for that first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdu_cnt  <= '0;
      s1_start <= 1'b0;
      s1_div   <= 1'b0;
    end else begin
      s1_start <= !ins_bubble && i_D_MduStart;
      s1_div   <= i_D_MduDiv;
      if (s1_start)
        mdu_cnt <= s1_div ? MDU_CW'(DIV_CYC) : MDU_CW'(MULT_CYC);
      else if (mdu_cnt != '0)
        mdu_cnt <= mdu_cnt - 1'b1;
    end
  end

  assign o_MduBusy = (mdu_cnt != '0);
  assign stall_mdu = i_D_valid && (i_D_MduUse || i_D_MduStart) && (o_MduBusy || s1_start);
  assign o_Stall   = stall_hz || stall_mdu;
`else
  assign o_Stall   = stall_hz;
`endif

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Directed bench for hazard_fwd_scoreboard: stimulus pushes expected
// stall/forward values, a negedge monitor pops and compares.
module tb_hazard_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_valid;
  logic [9:0]  D_Src;
  logic [7:0]  D_Tuse;
  logic [4:0]  D_WAddr;
  logic        D_WEn;
  logic [3:0]  D_Tnew;
  logic        Stall;
  logic [11:0] Fwd;
`ifdef HFS_MDU_BUSY_EN
  logic        MduBusy;
`endif

  always #5 clk = ~clk;

  hazard_fwd_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .i_D_valid (D_valid),
    .i_D_Src   (D_Src),
    .i_D_Tuse  (D_Tuse),
    .i_D_WAddr (D_WAddr),
    .i_D_WEn   (D_WEn),
    .i_D_Tnew  (D_Tnew),
`ifdef HFS_MDU_BUSY_EN
    .i_D_MduStart (1'b0),
    .i_D_MduDiv   (1'b0),
    .i_D_MduUse   (1'b0),
    .o_MduBusy    (MduBusy),
`endif
    .o_Stall   (Stall),
    .o_Fwd     (Fwd)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic [11:0] fwd;
  } exp_t;

  exp_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  // Selects for consumer D, E, M (src0, src1 each), packed as o_Fwd.
  function automatic logic [11:0] fw(input int d0, d1, e0, e1, m0, m1);
    logic [11:0] v;
    v = '0;
    v[1:0]   = 2'(d0); v[3:2]   = 2'(d1);
    v[5:4]   = 2'(e0); v[7:6]   = 2'(e1);
    v[9:8]   = 2'(m0); v[11:10] = 2'(m1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] s0, s1, input logic [3:0] u0, u1,
                     input logic [4:0] wa, input logic we, input logic [3:0] tn);
    D_valid = v;
    D_Src   = {s1, s0};
    D_Tuse  = {u1, u0};
    D_WAddr = wa;
    D_WEn   = we;
    D_Tnew  = tn;
  endtask

  task automatic expect_out(input string name, input logic st, input logic [11:0] f);
    exp_t e;
    e.name  = name;
    e.stall = st;
    e.fwd   = f;
    exp_q.push_back(e);
  endtask

  task automatic flush();
    repeat (3) begin
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  always begin
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (Stall !== e.stall || Fwd !== e.fwd) begin
        n_err++;
        $display("FAIL %s: got stall=%0b fwd=%h, want stall=%0b fwd=%h",
                 e.name, Stall, Fwd, e.stall, e.fwd);
      end
    end
  end

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset_state", 0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ALU chain: Tnew == Tuse does not stall; result forwarded to E, then M.
    flush();
    step(); drv(1, 4, 5, 1, 1, 1, 1, 1);  expect_out("alu_prod",  0, '0);
    step(); drv(1, 1, 7, 1, 1, 6, 1, 1);  expect_out("alu_cons_d", 0, '0);
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("alu_cons_e", 0, fw(0,0,2,0,0,0));
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("alu_cons_m", 0, fw(0,0,0,0,3,0));

    // Load-use with Tuse=0: two stall cycles, released once lw reaches W.
    flush();
    step(); drv(1, 8, 0, 1, 1, 2, 1, 2);  expect_out("lu_lw",     0, '0);
    step(); drv(1, 2, 9, 0, 0, 0, 0, 0);  expect_out("lu_stall1", 1, '0);
    step();                               expect_out("lu_stall2", 1, '0);
    step();                               expect_out("lu_release", 0, '0);

    // Load-use with Tuse=1: one stall cycle, then E takes the value from W.
    flush();
    step(); drv(1, 8, 0, 1, 1, 2, 1, 2);  expect_out("lu1_lw",    0, '0);
    step(); drv(1, 2, 0, 1, 1, 14, 1, 1); expect_out("lu1_stall", 1, '0);
    step();                               expect_out("lu1_go",    0, '0);
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("lu1_e_w",   0, fw(0,0,3,0,0,0));

    // Priority: two ready writers of $3; nearest wins, duplicate srcs agree.
    flush();
    step(); drv(1, 0, 0, 1, 1, 3, 1, 0);  expect_out("pri_x1",    0, '0);
    step(); drv(1, 0, 0, 1, 1, 3, 1, 0);  expect_out("pri_x2",    0, '0);
    step(); drv(1, 3, 3, 1, 1, 10, 1, 1); expect_out("pri_d",     0, fw(1,1,0,0,0,0));
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("pri_e",     0, fw(0,0,2,2,0,0));

    // Register 0 is never a hazard source.
    flush();
    step(); drv(1, 0, 0, 1, 1, 0, 1, 2);  expect_out("r0_prod",   0, '0);
    step(); drv(1, 0, 0, 0, 0, 0, 0, 0);  expect_out("r0_cons",   0, '0);

    // Asynchronous reset in the middle of a stall.
    flush();
    step(); drv(1, 8, 0, 1, 1, 2, 1, 2);  expect_out("rst_lw",    0, '0);
    step(); drv(1, 2, 9, 0, 0, 0, 0, 0);  expect_out("rst_stall", 1, '0);
    step(); reset = 1'b1;                 expect_out("rst_mid",   0, '0);
    step(); reset = 1'b0;                 expect_out("rst_after", 0, '0);

    // W forward to E while D must not pick it up.
    flush();
    step(); drv(1, 0, 0, 1, 1, 5, 1, 1);  expect_out("w_prod",    0, '0);
    step(); drv(0, 0, 0, 0, 0, 0, 0, 0);  expect_out("w_gap",     0, '0);
    step(); drv(1, 5, 0, 1, 1, 12, 1, 1); expect_out("w_d_from_m", 0, fw(2,0,0,0,0,0));
    step(); drv(1, 5, 5, 1, 1, 13, 1, 1); expect_out("w_e_from_w", 0, fw(0,0,3,0,0,0));

    // A bubble in D never stalls even with a pending hazard on its fields.
    flush();
    step(); drv(1, 8, 0, 1, 1, 2, 1, 2);  expect_out("nv_lw",     0, '0);
    step(); drv(0, 2, 0, 0, 0, 0, 0, 0);  expect_out("nv_bubble", 0, '0);

    step(); drv(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
